// File: rtl/shared_result_acc.sv
// shared_result_acc
// Consumer for the 2-bit shared add/sub unit. It accepts one result per
// valid/ready handshake and interprets s as follows:
//   - m=0 (add): s is unsigned.
//   - m=1 (sub): s is two's complement.
// Each result is added into a signed, saturating accumulator. After BURST
// results the block enters DONE and holds the checksum.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    begin a new run (acts from IDLE or DONE)
//   clear    synchronous abort to IDLE; overrides start
//   in_valid result present on m/s
//   in_ready block accepts a result this cycle (RUN only)
//   m        result mode: 0 = add (unsigned s), 1 = sub (signed s)
//   s        2-bit result {s1,s0}
//   acc_out  accumulated signed sum
//   op_cnt   results accepted in the current run
//   ovf      sticky saturation flag for the current run
//   done     high while in DONE
module shared_result_acc #(
  parameter int ACC_W = 8,
  parameter int BURST = 16,
  parameter int CNT_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    m,
  input  logic [1:0]              s,
  output logic signed [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0]        op_cnt,
  output logic                    ovf,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

  state_t           state;
  logic             xfer;
  logic [ACC_W:0]   operand;
  logic [ACC_W:0]   sum;
  logic             sat_hi;
  logic             sat_lo;

  assign in_ready = (state == RUN);
  assign done     = (state == DONE);
  assign xfer     = in_valid && (state == RUN);

  // The operand is forced to zero unless a transfer happens, so m and s are
  // never seen by the adder while they are don't-care.
  always_comb begin
    operand = '0;
    if (xfer) begin
      if (m) operand = {{(ACC_W-1){s[1]}}, s};
      else   operand = {{(ACC_W-1){1'b0}}, s};
    end
    sum = {acc_out[ACC_W-1], acc_out} + operand;
    // The top two bits disagree only when the result is out of the ACC_W range.
    // The extra sign bit then tells which side it overflowed on.
    sat_hi = (sum[ACC_W] == 1'b0) && (sum[ACC_W-1] == 1'b1);
    sat_lo = (sum[ACC_W] == 1'b1) && (sum[ACC_W-1] == 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc_out <= '0;
      op_cnt  <= '0;
      ovf     <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      acc_out <= '0;
      op_cnt  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            acc_out <= '0;
            op_cnt  <= '0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (sat_hi) begin
              acc_out <= ACC_MAX;
              ovf     <= 1'b1;
            end else if (sat_lo) begin
              acc_out <= ACC_MIN;
              ovf     <= 1'b1;
            end else begin
              acc_out <= sum[ACC_W-1:0];
            end
            op_cnt <= op_cnt + CNT_W'(1);
            if (op_cnt == LAST_CNT) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_result_acc.sv
// Bench for shared_result_acc. It drives two instances from the same inputs:
//   - an 8-bit accumulator (the default configuration);
//   - a 4-bit accumulator, which saturates quickly.
// A reference model in plain integer arithmetic predicts the outputs of each
// instance after every clock edge.
module tb_shared_result_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, clear, in_valid, m;
  logic [1:0] s;

  logic              ready_a, ovf_a, done_a;
  logic signed [7:0] acc_a;
  logic [4:0]        cnt_a;
  logic              ready_b, ovf_b, done_b;
  logic signed [3:0] acc_b;
  logic [4:0]        cnt_b;

  int checks = 0;
  int failures = 0;

  // Model state, index 0 = 8-bit instance, 1 = 4-bit instance.
  // Phase: 0 idle, 1 running, 2 done.
  int width [2] = '{8, 4};
  int burst = 16;
  int md_acc [2];
  int md_cnt [2];
  int md_ovf [2];
  int md_ph  [2];

  always #5 clk = ~clk;

  shared_result_acc #(.ACC_W(8), .BURST(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(ready_a), .m(m), .s(s),
    .acc_out(acc_a), .op_cnt(cnt_a), .ovf(ovf_a), .done(done_a)
  );

  shared_result_acc #(.ACC_W(4), .BURST(16), .CNT_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(ready_b), .m(m), .s(s),
    .acc_out(acc_b), .op_cnt(cnt_b), .ovf(ovf_b), .done(done_b)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      md_acc[i] = 0; md_cnt[i] = 0; md_ovf[i] = 0; md_ph[i] = 0;
    end
  endtask

  task automatic model_edge();
    int v, sum, mx, mn;
    for (int i = 0; i < 2; i++) begin
      mx = (1 << (width[i] - 1)) - 1;
      mn = -(1 << (width[i] - 1));
      if (clear) begin
        md_ph[i] = 0; md_acc[i] = 0; md_cnt[i] = 0; md_ovf[i] = 0;
      end else if (md_ph[i] != 1) begin
        if (start) begin
          md_ph[i] = 1; md_acc[i] = 0; md_cnt[i] = 0; md_ovf[i] = 0;
        end
      end else if (in_valid) begin
        v = int'(s);
        if (m && v >= 2) v = v - 4;
        sum = md_acc[i] + v;
        if (sum > mx) begin
          md_acc[i] = mx; md_ovf[i] = 1;
        end else if (sum < mn) begin
          md_acc[i] = mn; md_ovf[i] = 1;
        end else begin
          md_acc[i] = sum;
        end
        md_cnt[i]++;
        if (md_cnt[i] == burst) md_ph[i] = 2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".acc_a"},   acc_a,   md_acc[0]);
    check({tag, ".cnt_a"},   cnt_a,   md_cnt[0]);
    check({tag, ".ovf_a"},   ovf_a,   md_ovf[0]);
    check({tag, ".rdy_a"},   ready_a, (md_ph[0] == 1) ? 1 : 0);
    check({tag, ".done_a"},  done_a,  (md_ph[0] == 2) ? 1 : 0);
    check({tag, ".acc_b"},   acc_b,   md_acc[1]);
    check({tag, ".cnt_b"},   cnt_b,   md_cnt[1]);
    check({tag, ".ovf_b"},   ovf_b,   md_ovf[1]);
    check({tag, ".rdy_b"},   ready_b, (md_ph[1] == 1) ? 1 : 0);
    check({tag, ".done_b"},  done_b,  (md_ph[1] == 2) ? 1 : 0);
  endtask

  // One clock: apply inputs, take the edge in DUT and model, check 1 ns later.
  task automatic cycle(input string tag, input logic st, input logic cl,
                       input logic v, input logic mm, input logic [1:0] ss);
    start = st; clear = cl; in_valid = v; m = mm; s = ss;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0; m = 1'b0; s = 2'b00;
    model_reset();
    #12;
    check_all("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset_idle");

    // Full burst of +3: the 8-bit instance reaches 48, the 4-bit one pins at 7.
    cycle("start1", 1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 16; i++) cycle("add3", 0, 0, 1, 0, 2'b11);
    check("done_add3_acc", acc_a, 48);
    check("sat4_acc", acc_b, 7);
    check("sat4_ovf", ovf_b, 1);
    cycle("done_ignores_valid", 0, 0, 1, 0, 2'b11);

    // Full burst of -2 -> -32 in the 8-bit instance.
    cycle("start2", 1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 16; i++) cycle("sub2", 0, 0, 1, 1, 2'b10);
    check("done_sub2_acc", acc_a, -32);

    // Restart from DONE, then gapped +1 transfers (m=1, s=01).
    cycle("restart", 1, 0, 0, 0, 2'b00);
    check("restart_acc", acc_a, 0);
    for (int i = 0; i < 8; i++) begin
      cycle("gap_xfer", 0, 0, 1, 1, 2'b01);
      cycle("gap_idle", 0, 0, 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    check("gap_acc", acc_a, 8);
    check("gap_cnt", cnt_a, 8);
    cycle("start_in_run", 1, 0, 1, 0, 2'b10);

    // Clear and start together with a valid offer: clear wins.
    cycle("clear_start", 1, 1, 1, 0, 2'b11);
    check("clear_idle_rdy", ready_a, 0);
    cycle("idle_hold", 0, 0, 1, 0, 2'b11);

    // Randomised traffic with occasional start/clear.
    cycle("start_rand", 1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 200; i++) begin
      cycle("rand",
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)));
    end

    // Asynchronous reset between edges during a run.
    cycle("start_arst", 1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 5; i++) cycle("pre_arst", 0, 0, 1, 0, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_arst_idle", 0, 0, 1, 0, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_result_acc.md
Name: shared_result_acc

Overview:
- Downstream consumer of the 2-bit shared add/sub unit.
- Accepts one result per handshake: 2-bit result s = {s1,s0} plus the mode bit m that produced it.
- Interprets s as unsigned (m=0, add) or two's complement (m=1, sub) and accumulates into a signed saturating register.
- Counts a burst of BURST results, then reports done. Lets the lab bench or a host controller sweep all operand combinations and read back one checksum.

Parameters:
- ACC_W, 8, accumulator width in bits, signed two's complement, min 4.
- BURST, 16, results accepted per run before entering DONE, min 1.
- CNT_W, 5, op counter width; must hold BURST (ceil(log2(BURST+1))).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run (sampled level; acts from IDLE or DONE).
- clear  input  1  synchronous abort/clear to IDLE; higher priority than start.
- in_valid  input  1  result present on m/s.
- in_ready  output  1  block can accept a result this cycle.
- m  input  1  mode of the result: 0 = add (s unsigned 0..3), 1 = sub (s signed -2..1).
- s  input  2  result bits {s1,s0}.
- acc_out  output  ACC_W  current accumulated sum, signed.
- op_cnt  output  CNT_W  results accepted in current run.
- ovf  output  1  sticky saturation flag for current run.
- done  output  1  high while in DONE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, acc_out=0, op_cnt=0, ovf=0, done=0, in_ready=0.
- FSM states: IDLE, RUN, DONE. Outputs are registered except in_ready and done, which decode from state: in_ready=1 only in RUN; done=1 only in DONE.
- IDLE:
  - start=1 and clear=0 -> next state RUN; acc_out, op_cnt and ovf cleared on the same edge.
  - Otherwise hold.
- RUN:
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - On transfer: operand v = zero-extend(s) if m=0, sign-extend(s) if m=1, to ACC_W+1 bits.
  - sum = acc_out + v, computed in ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, acc_out <= max positive and ovf <= 1.
  - If sum < -2^(ACC_W-1), acc_out <= min negative and ovf <= 1.
  - Otherwise acc_out <= sum.
  - op_cnt increments by 1 on every transfer.
  - Latency: a result accepted at edge k is visible on acc_out/op_cnt after edge k, one cycle.
  - Transfer that makes op_cnt == BURST -> next state DONE on the same edge; that final result is included.
  - start while in RUN is ignored.
  - in_valid=0 cycles leave all state unchanged; no timeout.
- DONE:
  - Hold acc_out, op_cnt and ovf; in_ready=0, so in_valid is ignored.
  - start=1 -> RUN with acc_out, op_cnt and ovf cleared (new run).
- clear=1 in any state: next state IDLE; acc_out=0, op_cnt=0, ovf=0. Any transfer offered that cycle is discarded, not accumulated.
- clear and start in the same cycle: clear wins; end in IDLE.
- ovf is sticky: once set it stays set until clear, reset, or a new start. Saturation does not stop counting.
- Async reset mid-run: immediate return to reset values; no partial update survives.
- m and s are don't-care when in_valid=0 or in_ready=0; no X may propagate into acc_out from them.

Test Plan:
- Reset, then start; feed 16 transfers with m=0, s=3 (back-to-back valid) -> acc_out steps 3,6,…,48; op_cnt=16; done=1 the cycle after the 16th transfer; ovf=0; in_ready=0 in DONE.
- Start; feed 16 transfers with m=1, s=2'b10 -> acc_out=-32 (8'hE0), ovf=0. Then start again -> acc_out=0, op_cnt=0 next cycle, state RUN.
- ACC_W=4, BURST=16: feed m=0, s=3 repeatedly -> acc 3,6; third transfer saturates to 7 and ovf=1; ovf stays 1 and acc stays 7 through done.
- Gapped valid: alternate in_valid 1/0 for 8 transfers of m=1, s=2'b01 -> acc_out=8 after 8 transfers, op_cnt=8, no change on idle cycles, still RUN.
- Assert clear and start in the same cycle mid-run with a valid transfer -> IDLE, acc_out=0, op_cnt=0; the offered transfer is not counted.
- Drop rst_n asynchronously between clock edges during RUN -> outputs zero immediately, in_ready=0, done=0; after release the block stays in IDLE until start.
